// File: rtl/intra_pkg.sv
// intra_pkg: shared state type, datapath widths and index packing for the 4x4 transform
package intra_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;
  localparam int RES_W = 8;
  localparam int ROW_W = 11;
  localparam int COL_W = 14;
  function automatic logic [3:0] coeff_pos(input logic [1:0] i, input logic [1:0] j);
    return {i, j};
  endfunction
endpackage

// File: rtl/dct4_butterfly.sv
// dct4_butterfly: combinational 4-point H.264 forward core transform
module dct4_butterfly #(
  parameter int IN_W = 11
) (
  input  logic signed [IN_W-1:0] x0,
  input  logic signed [IN_W-1:0] x1,
  input  logic signed [IN_W-1:0] x2,
  input  logic signed [IN_W-1:0] x3,
  output logic signed [IN_W+2:0] y0,
  output logic signed [IN_W+2:0] y1,
  output logic signed [IN_W+2:0] y2,
  output logic signed [IN_W+2:0] y3
);
  logic signed [IN_W+2:0] s0, s1, d0, d1;
  // sums/differences at full output width so the doubled terms cannot wrap
  always_comb begin
    s0 = x0 + x3;
    s1 = x1 + x2;
    d0 = x0 - x3;
    d1 = x1 - x2;
    y0 = s0 + s1;
    y1 = (d0 <<< 1) + d1;
    y2 = s0 - s1;
    y3 = d0 - (d1 <<< 1);
  end
endmodule

// File: rtl/intra_dct4x4.sv
// intra_dct4x4: collects a 4x4 residual block, row then column butterfly passes, streams 16 coefficients
module intra_dct4x4 import intra_pkg::*; #(
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        residual_flat,
  input  logic               residual_ready,
  input  logic [1:0]         mode,
  output logic               DCT_clear,
  output logic [COEFF_W-1:0] coeff_out,
  output logic [3:0]         coeff_index,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic               block_done,
  output logic [1:0]         mode_out,
  output logic               overrun
);
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [3:0] idx;
  logic signed [COL_W-1:0] blk [16];
  logic signed [ROW_W-1:0] bx [4];
  logic signed [COL_W-1:0] by [4];
  logic load, accept;
  dct4_butterfly #(.IN_W(ROW_W)) u_bfly (
    .x0(bx[0]), .x1(bx[1]), .x2(bx[2]), .x3(bx[3]),
    .y0(by[0]), .y1(by[1]), .y2(by[2]), .y3(by[3])
  );
  // butterfly operands: row cnt of the buffer during ROW, column cnt during COL
  always_comb
    for (int k = 0; k < 4; k++)
      bx[k] = ROW_W'(state == COL ? blk[coeff_pos(2'(k), cnt)] : blk[coeff_pos(cnt, 2'(k))]);
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next-state: load four rows, four row passes, four column passes, sixteen outputs
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (residual_ready) state_nx = LOAD;
      LOAD:    if (residual_ready && cnt == 2'd3) state_nx = ROW;
      ROW:     if (cnt == 2'd3) state_nx = COL;
      COL:     if (cnt == 2'd3) state_nx = OUT;
      OUT:     if (accept && idx == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // outputs decoded from state so an async reset clears them immediately
  always_comb begin
    DCT_clear   = state == IDLE || state == LOAD;
    coeff_valid = state == OUT;
    accept      = coeff_valid && coeff_ready;
    load        = residual_ready && DCT_clear;
    block_done  = accept && idx == 4'd15;
    coeff_index = idx;
    coeff_out   = coeff_valid ? COEFF_W'(blk[idx]) : '0;
  end
  // buffer writes, counters, captured mode and sticky overrun
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt      <= '0;
      idx      <= '0;
      mode_out <= '0;
      overrun  <= 1'b0;
      for (int k = 0; k < 16; k++) blk[k] <= '0;
    end else begin
      if (residual_ready && !DCT_clear) overrun <= 1'b1;
      if (load && state == IDLE) mode_out <= mode;
      if (load || state == ROW || state == COL) cnt <= cnt + 2'd1;
      if (accept) idx <= idx + 4'd1;
      for (int k = 0; k < 4; k++) begin
        if (load) blk[coeff_pos(cnt, 2'(k))] <= COL_W'($signed(residual_flat[RES_W*k +: RES_W]));
        if (state == ROW) blk[coeff_pos(cnt, 2'(k))] <= COL_W'($signed(by[k][ROW_W-1:0]));
        if (state == COL) blk[coeff_pos(2'(k), cnt)] <= by[k];
      end
    end
endmodule

// File: tb/tb_intra_dct4x4.sv
// tb_intra_dct4x4: directed block tests for the 4x4 forward transform stage
module tb_intra_dct4x4;
  typedef logic signed [15:0] blk_t [16];
  typedef logic [31:0] rows_t [4];
  logic clk = 0, reset = 0, residual_ready = 0, coeff_ready = 1;
  logic [31:0] residual_flat = '0;
  logic [1:0] mode = '0;
  logic DCT_clear, coeff_valid, block_done, overrun;
  logic [15:0] coeff_out;
  logic [3:0] coeff_index;
  logic [1:0] mode_out;
  int errors = 0, checks = 0;
  rows_t r_zero = '{32'h0, 32'h0, 32'h0, 32'h0};
  rows_t r_one  = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
  rows_t r_neg  = '{32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080};
  rows_t r_x00  = '{32'h00000001, 32'h0, 32'h0, 32'h0};
  rows_t r_x03  = '{32'h01000000, 32'h0, 32'h0, 32'h0};
  rows_t r_x30  = '{32'h0, 32'h0, 32'h0, 32'h00000001};
  blk_t e_zero = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
  blk_t e_one  = '{16,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
  blk_t e_neg  = '{-2048,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
  blk_t e_x00  = '{1,2,1,1, 2,4,2,2, 1,2,1,1, 1,2,1,1};
  blk_t e_x03  = '{1,-2,1,-1, 2,-4,2,-2, 1,-2,1,-1, 1,-2,1,-1};
  blk_t e_x30  = '{1,2,1,1, -2,-4,-2,-2, 1,2,1,1, -1,-2,-1,-1};
  intra_dct4x4 #(.COEFF_W(16)) dut (
    .clk(clk), .reset(reset), .residual_flat(residual_flat), .residual_ready(residual_ready),
    .mode(mode), .DCT_clear(DCT_clear), .coeff_out(coeff_out), .coeff_index(coeff_index),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .block_done(block_done),
    .mode_out(mode_out), .overrun(overrun)
  );
  always #5 clk = ~clk;
  // strobes four rows; gap>0 inserts gap idle cycles between strobes; leaves row-3 strobe driven
  task automatic send_block(input rows_t rows, input int gap, input logic [1:0] md);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      residual_flat = rows[r];
      residual_ready = 1;
      mode = r == 0 ? md : ~md;
      if (r < 3 && gap > 0) begin
        @(negedge clk);
        residual_ready = 0;
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask
  // follows a row-3 strobe: checks compute latency, then consumes all 16 coefficients
  task automatic drain_block(input blk_t exp, input logic [1:0] md, input bit toggle, input int inj);
    int k = 0;
    int cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      residual_ready = c == inj;
      if (c == inj) residual_flat = 32'h7F807F80;
      #1;
      if (c == 1) begin
        checks++;
        if (DCT_clear !== 1'b0) begin errors++; $display("FAIL clear_low: got %b want 0", DCT_clear); end
      end
      if (c == 8) begin
        checks++;
        if (coeff_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b want 0 at t+8", coeff_valid); end
      end
    end
    @(negedge clk);
    residual_ready = 0;
    while (k < 16 && cyc < 64) begin
      coeff_ready = !toggle || cyc % 2 == 0;
      #1;
      checks++;
      if (coeff_valid !== 1'b1 || coeff_index !== 4'(k) || coeff_out !== exp[k] || mode_out !== md ||
          block_done !== (coeff_ready && k == 15)) begin
        errors++;
        $display("FAIL out[%0d]: got valid=%b idx=%0d coeff=%0d mode=%b done=%b, want valid=1 idx=%0d coeff=%0d mode=%b done=%b",
                 k, coeff_valid, coeff_index, $signed(coeff_out), mode_out, block_done,
                 k, exp[k], md, coeff_ready && k == 15);
      end
      if (coeff_ready) k++;
      cyc++;
      @(negedge clk);
    end
    coeff_ready = 1;
    checks++;
    if (k != 16) begin errors++; $display("FAIL drain_timeout: got %0d outputs want 16", k); end
    #1;
    checks++;
    if (DCT_clear !== 1'b1 || coeff_valid !== 1'b0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL after_block: got clear=%b valid=%b done=%b want 1 0 0", DCT_clear, coeff_valid, block_done);
    end
  endtask
  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({DCT_clear, coeff_valid, block_done, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got clear/valid/done/ovr=%b want 1000", {DCT_clear, coeff_valid, block_done, overrun});
    end
    checks++;
    if (coeff_out !== 16'h0) begin errors++; $display("FAIL reset_coeff: got %h want 0000", coeff_out); end
    checks++;
    if (coeff_index !== 4'h0) begin errors++; $display("FAIL reset_index: got %0d want 0", coeff_index); end
    checks++;
    if (mode_out !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b want 00", mode_out); end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (DCT_clear !== 1'b1 || coeff_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got clear=%b valid=%b want 1 0", DCT_clear, coeff_valid);
    end
  endtask
  task automatic test_zero;
    send_block(r_zero, 0, 2'b00);
    drain_block(e_zero, 2'b00, 0, 0);
  endtask
  task automatic test_dc;
    send_block(r_one, 0, 2'b01);
    drain_block(e_one, 2'b01, 0, 0);
    send_block(r_neg, 0, 2'b11);
    drain_block(e_neg, 2'b11, 0, 0);
  endtask
  task automatic test_gaps;
    send_block(r_x00, 3, 2'b10);
    drain_block(e_x00, 2'b10, 0, 0);
  endtask
  task automatic test_backpressure;
    send_block(r_x03, 0, 2'b01);
    drain_block(e_x03, 2'b01, 1, 0);
  endtask
  task automatic test_overrun;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clean: got %b want 0", overrun); end
    send_block(r_x30, 0, 2'b11);
    drain_block(e_x30, 2'b11, 0, 6);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
  endtask
  task automatic test_reset_mid_out;
    send_block(r_one, 0, 2'b11);
    @(negedge clk);
    residual_ready = 0;
    repeat (8) @(negedge clk);
    coeff_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (coeff_valid !== 1'b1 || coeff_index !== 4'd3 || mode_out !== 2'b11) begin
      errors++;
      $display("FAIL mid_out: got valid=%b idx=%0d mode=%b want 1 3 11", coeff_valid, coeff_index, mode_out);
    end
    reset = 0;
    #1;
    checks++;
    if ({DCT_clear, coeff_valid, block_done, overrun} !== 4'b1000 || coeff_out !== 16'h0 ||
        coeff_index !== 4'h0 || mode_out !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got clear/valid/done/ovr=%b coeff=%h idx=%0d mode=%b want 1000 0000 0 00",
               {DCT_clear, coeff_valid, block_done, overrun}, coeff_out, coeff_index, mode_out);
    end
    @(negedge clk);
    reset = 1;
    send_block(r_x00, 0, 2'b01);
    drain_block(e_x00, 2'b01, 0, 0);
  endtask
  initial begin
    test_reset;
    test_zero;
    test_dc;
    test_gaps;
    test_backpressure;
    test_overrun;
    test_reset_mid_out;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
